// File: rtl/mcpu_pkg.sv
// mcpu_pkg: opcodes, functs, ALU control codes, FSM states and decode helpers for multi_cycle_cpu
package mcpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    return op == OP_RTYPE ? fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}
                          : op inside {OP_ADDI, OP_SLTI, OP_BEQ, OP_BNE, OP_LW, OP_SW};
  endfunction
  function automatic alu_op_e alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE)
      return fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
             fn == FN_SLT ? ALU_SLT : ALU_ADD;
    return op == OP_SLTI ? ALU_SLT : op inside {OP_BEQ, OP_BNE} ? ALU_SUB : ALU_ADD;
  endfunction
endpackage

// File: rtl/mcpu_ctrl_fsm.sv
// mcpu_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with a registered retire pulse
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       misaligned,
  output state_e     state,
  output logic       retire
);
  logic is_br, is_mem, is_sw;
  assign is_br  = opcode inside {OP_BEQ, OP_BNE};
  assign is_sw  = opcode == OP_SW;
  assign is_mem = is_sw || opcode == OP_LW;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state  <= FETCH;
      retire <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH:  if (imem_ready) state <= DECODE;
        DECODE: state <= is_legal(opcode, funct) ? EXEC : HALT;
        EXEC:
          if (is_br) begin
            state  <= FETCH;
            retire <= 1'b1;
          end else state <= is_mem ? (misaligned ? HALT : MEM) : WB;
        MEM:
          if (dmem_ready) begin
            state  <= is_sw ? FETCH : WB;
            retire <= is_sw;
          end
        WB: begin
          state  <= FETCH;
          retire <= 1'b1;
        end
        default: state <= HALT;
      endcase
    end
endmodule

// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: multi-cycle MIPS-subset core with req/ready memories; MCPU_PERF_CNT_EN adds cycle/instret counters
module multi_cycle_cpu
  import mcpu_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NREG     = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PERF_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              retire_o,
  output logic              halt_o
`ifdef MCPU_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt_o,
  output logic [PERF_W-1:0] instret_cnt_o
`endif
);
  localparam int RW = $clog2(NREG);
  state_e            state;
  logic [DATA_W-1:0] pc, alu_q, mdr, a, b, opb, imm, alu_y;
  logic [DATA_W-1:0] rf [NREG];
  logic [31:0]       ir;
  logic [5:0]        op, fn;
  logic [RW-1:0]     rs, rt, rd, wa;
  logic              is_br, taken, unused_ir;
  alu_op_e           ctl;
  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign rs        = ir[21+:RW];
  assign rt        = ir[16+:RW];
  assign rd        = ir[11+:RW];
  assign wa        = op == OP_RTYPE ? rd : rt;
  assign unused_ir = ^ir;
  assign imm       = DATA_W'(signed'(ir[15:0]));
  assign a         = rf[rs];
  assign b         = rf[rt];
  assign is_br     = op inside {OP_BEQ, OP_BNE};
  assign opb       = op == OP_RTYPE || is_br ? b : imm;
  assign ctl       = alu_ctrl(op, fn);
  always_comb
    alu_y = ctl == ALU_SUB ? a - opb :
            ctl == ALU_AND ? a & opb :
            ctl == ALU_OR  ? a | opb :
            ctl == ALU_SLT ? DATA_W'($signed(a) < $signed(opb)) : a + opb;
  assign taken = is_br && ((alu_y == '0) == (op == OP_BEQ));
  mcpu_ctrl_fsm u_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .opcode     (op),
    .funct      (fn),
    .imem_ready (imem_ready_i),
    .dmem_ready (dmem_ready_i),
    .misaligned (|alu_y[1:0]),
    .state      (state),
    .retire     (retire_o)
  );
  // state is already FETCH while reset is held, so the fetch request is gated by reset
  assign imem_req_o   = rst_i && state == FETCH;
  assign imem_addr_o  = pc;
  assign dmem_req_o   = state == MEM;
  assign dmem_we_o    = state == MEM && op == OP_SW;
  assign dmem_addr_o  = alu_q;
  assign dmem_wdata_o = b;
  assign halt_o       = state == HALT;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      pc    <= RESET_PC;
      ir    <= '0;
      alu_q <= '0;
      mdr   <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (state == FETCH && imem_ready_i) begin
        ir <= imem_rdata_i;
        pc <= pc + DATA_W'(4);
      end
      if (state == EXEC) begin
        alu_q <= alu_y;
        if (taken) pc <= pc + {imm[DATA_W-3:0], 2'b00};
      end
      if (state == MEM && dmem_ready_i) mdr <= dmem_rdata_i;
      if (state == WB && wa != '0) rf[wa] <= op == OP_LW ? mdr : alu_q;
    end
`ifdef MCPU_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cycle_cnt_o   <= '0;
      instret_cnt_o <= '0;
    end else begin
      cycle_cnt_o   <= cycle_cnt_o + PERF_W'(1);
      instret_cnt_o <= instret_cnt_o + PERF_W'(retire_o);
    end
`else
  logic unused_perf;
  assign unused_perf = PERF_W != 0;
`endif
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: scoreboard bench with fetch, retire-gap and store queues plus a stalling data memory
module tb_multi_cycle_cpu;
  logic        clk = 1'b0, rst_n;
  logic        imem_req_o, imem_ready_i, dmem_req_o, dmem_we_o, dmem_ready_i, retire_o, halt_o;
  logic [31:0] imem_addr_o, imem_rdata_i, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  typedef struct {logic [31:0] a; logic [31:0] d;} st_t;
  logic [31:0] q_fetch [$];
  int          q_ret [$];
  st_t         q_st [$];
  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];
  int          n_chk = 0, n_fail = 0, cyc = 0, last_ret = 0, ndmem = 0, d_lat = 0, d_cnt = 0;
  logic        d_busy = 1'b0, d_we;
  logic [31:0] d_addr, d_wdata, ld_pc;
  multi_cycle_cpu #(.RESET_PC(32'h100)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ready_i (dmem_ready_i),
    .dmem_rdata_i (dmem_rdata_i),
    .retire_o     (retire_o),
    .halt_o       (halt_o)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fi(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] fr(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction
  task automatic put(input logic [31:0] w, input int lat);
    imem[ld_pc] = w;
    q_fetch.push_back(ld_pc);
    if (lat > 0) q_ret.push_back(lat);
    ld_pc += 4;
  endtask
  task automatic tick();
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    if (retire_o) begin
      if (q_ret.size() == 0) chk("retire_spurious", retire_o, 0);
      else begin
        chk("retire_gap", cyc - last_ret, q_ret.pop_front());
        last_ret = cyc;
      end
    end
    if (imem_req_o) begin
      if (q_fetch.size() == 0) chk("fetch_spurious", imem_req_o, 0);
      else chk("fetch_addr", imem_addr_o, q_fetch.pop_front());
      imem_ready_i = 1'b1;
      imem_rdata_i = imem.exists(imem_addr_o) ? imem[imem_addr_o] : 32'h0;
    end
    if (dmem_req_o) begin
      ndmem++;
      if (!d_busy) begin
        d_busy = 1'b1;
        d_cnt = dmem_we_o ? 0 : d_lat;
        d_addr = dmem_addr_o;
        d_we = dmem_we_o;
        d_wdata = dmem_wdata_o;
      end else begin
        chk("dmem_addr_stable", dmem_addr_o, d_addr);
        chk("dmem_we_stable", dmem_we_o, d_we);
        chk("dmem_wdata_stable", dmem_wdata_o, d_wdata);
      end
      if (d_cnt > 0) d_cnt--;
      else begin
        dmem_ready_i = 1'b1;
        d_busy = 1'b0;
        if (dmem_we_o) begin
          dmem[dmem_addr_o] = dmem_wdata_o;
          if (q_st.size() == 0) chk("store_spurious", dmem_we_o, 0);
          else begin
            st_t e = q_st.pop_front();
            chk("store_addr", dmem_addr_o, e.a);
            chk("store_data", dmem_wdata_o, e.d);
          end
        end else dmem_rdata_i = dmem.exists(dmem_addr_o) ? dmem[dmem_addr_o] : 32'h0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    d_busy = 1'b0;
    ndmem = 0;
    #1;
    chk("rst_imem_req", imem_req_o, 0);
    chk("rst_dmem_req", dmem_req_o, 0);
    chk("rst_retire", retire_o, 0);
    chk("rst_halt", halt_o, 0);
    chk("rst_imem_addr", imem_addr_o, 32'h100);
  endtask
  task automatic run(input int extra, input int budget);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_imem_req", imem_req_o, 1);
    chk("rel_imem_addr", imem_addr_o, 32'h100);
    chk("rel_dmem_req", dmem_req_o, 0);
    chk("rel_dmem_we", dmem_we_o, 0);
    chk("rel_dmem_addr", dmem_addr_o, 0);
    chk("rel_dmem_wdata", dmem_wdata_o, 0);
    last_ret = cyc;
    while ((q_fetch.size() + q_ret.size() + q_st.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("timeout_pending", q_fetch.size() + q_ret.size() + q_st.size(), 0);
    repeat (extra) tick();
  endtask
  task automatic expect_halt(input string tag);
    chk({tag, "_halt"}, halt_o, 1);
    chk({tag, "_no_dmem"}, ndmem, 0);
    chk({tag, "_no_fetch"}, imem_req_o, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    imem_rdata_i = '0;
    dmem_rdata_i = '0;
    repeat (2) @(negedge clk);
    chk("init_imem_req", imem_req_o, 0);
    chk("init_imem_addr", imem_addr_o, 32'h100);
    chk("init_dmem_req", dmem_req_o, 0);
    chk("init_retire", retire_o, 0);
    chk("init_halt", halt_o, 0);
    // arithmetic, signed compares, stalled load, branches and r0 write
    ld_pc = 32'h100;
    d_lat = 2;
    put(fi(6'h08, 0, 1, 5), 4);
    put(fi(6'h08, 0, 2, -3), 4);
    put(fr(1, 2, 3, 6'h20), 4);
    put(fi(6'h2B, 0, 3, 8), 4);
    put(fi(6'h23, 0, 4, 8), 7);
    put(fi(6'h2B, 0, 4, 12), 4);
    put(fr(2, 1, 5, 6'h2A), 4);
    put(fi(6'h2B, 0, 5, 16), 4);
    put(fi(6'h05, 0, 0, 4), 3);
    put(fi(6'h0A, 1, 6, -1), 4);
    put(fr(1, 2, 7, 6'h25), 4);
    put(fr(1, 2, 8, 6'h24), 4);
    put(fr(2, 1, 9, 6'h22), 4);
    put(fi(6'h2B, 0, 7, 20), 4);
    put(fi(6'h2B, 0, 6, 24), 4);
    put(fi(6'h2B, 0, 8, 32), 4);
    put(fi(6'h2B, 0, 9, 36), 4);
    put(fi(6'h08, 0, 0, 7), 4);
    put(fi(6'h2B, 0, 0, 28), 4);
    put(fi(6'h04, 0, 0, -1), 3);
    repeat (2) q_ret.push_back(3);
    repeat (3) q_fetch.push_back(32'h14C);
    q_st.push_back('{32'd8, 32'd2});
    q_st.push_back('{32'd12, 32'd2});
    q_st.push_back('{32'd16, 32'd1});
    q_st.push_back('{32'd20, 32'hFFFF_FFFD});
    q_st.push_back('{32'd24, 32'd0});
    q_st.push_back('{32'd32, 32'd5});
    q_st.push_back('{32'd36, 32'hFFFF_FFF8});
    q_st.push_back('{32'd28, 32'd0});
    run(0, 200);
    // misaligned load halts without a data request
    do_reset();
    imem.delete();
    dmem.delete();
    ld_pc = 32'h100;
    put(fi(6'h08, 0, 1, 6), 4);
    put(fi(6'h23, 1, 2, 0), 0);
    run(10, 40);
    expect_halt("misaligned");
    // illegal opcode
    do_reset();
    imem.delete();
    ld_pc = 32'h100;
    put(32'hFC00_0000, 0);
    run(10, 20);
    expect_halt("bad_opcode");
    // illegal R-type funct
    do_reset();
    imem.delete();
    ld_pc = 32'h100;
    put(fr(1, 2, 3, 6'h21), 0);
    run(10, 20);
    expect_halt("bad_funct");
    // reset during a stalled load, then restart from RESET_PC
    do_reset();
    imem.delete();
    ld_pc = 32'h100;
    d_lat = 50;
    put(fi(6'h23, 0, 1, 0), 0);
    run(0, 20);
    for (int n = 0; n < 20 && ndmem < 3; n++) tick();
    chk("stall_req_held", dmem_req_o, 1);
    do_reset();
    d_lat = 0;
    q_fetch.push_back(32'h100);
    q_ret.push_back(5);
    q_fetch.push_back(32'h104);
    run(5, 40);
    chk("restart_halt", halt_o, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
